// File: rtl/inst_dec_pkg.sv
// Shared encodings, default field widths and the decoded-instruction record
// for the pipelined instruction decoder.
package inst_dec_pkg;

  localparam int IMM_ZERO  = 0;
  localparam int IMM_SIGN  = 1;
  localparam int IMM_PEROP = 2;

  // Opcode top-nibble values of instructions that never write a register
  localparam logic [3:0] NOWB_OPC_0 = 4'b0111;
  localparam logic [3:0] NOWB_OPC_1 = 4'b1100;
  localparam logic [3:0] NOWB_OPC_2 = 4'b1101;

  localparam int DEF_OPC_W  = 5;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_DATA_W = 16;

  typedef struct packed {
    logic [DEF_OPC_W-1:0]  aluop;
    logic [DEF_REG_AW-1:0] sel_a;
    logic [DEF_REG_AW-1:0] sel_b;
    logic [DEF_REG_AW-1:0] sel_d;
    logic [DEF_DATA_W-1:0] imm;
    logic                  regwe;
  } dec_fields_t;

  function automatic logic writes_back(input logic [3:0] opc_top);
    logic we;
    case (opc_top)
      NOWB_OPC_0: we = 1'b0;
      NOWB_OPC_1: we = 1'b0;
      NOWB_OPC_2: we = 1'b0;
      default:    we = 1'b1;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/inst_dec_fields.sv
// Combinational split of one instruction word into its decoded fields,
// including immediate extension.
module inst_dec_fields
  import inst_dec_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 3,
  parameter int IMM_W    = 8,
  parameter int DATA_W   = 16,
  parameter int IMM_MODE = 0
) (
  input  logic [INST_W-1:0] inst,
  output logic [OPC_W-1:0]  aluop,
  output logic [REG_AW-1:0] sel_a,
  output logic [REG_AW-1:0] sel_b,
  output logic [REG_AW-1:0] sel_d,
  output logic [DATA_W-1:0] imm,
  output logic              regwe
);

  logic             sign_ext_s;
  logic [IMM_W-1:0] imm_raw_s;

  assign aluop     = inst[INST_W-1 -: OPC_W];
  assign sel_a     = inst[INST_W-OPC_W-1 -: REG_AW];
  assign sel_b     = inst[INST_W-OPC_W-REG_AW-1 -: REG_AW];
  assign sel_d     = inst[INST_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign imm_raw_s = inst[IMM_W-1:0];
  assign regwe     = writes_back(aluop[OPC_W-1 -: 4]);

  // Choose extension kind; per-instruction mode keys off the opcode LSB
  always_comb begin
    sign_ext_s = 1'b0;
    case (IMM_MODE)
      IMM_SIGN:  sign_ext_s = 1'b1;
      IMM_PEROP: sign_ext_s = aluop[0];
      default:   sign_ext_s = 1'b0;
    endcase
  end

  // Widen the immediate field to the data width
  always_comb begin
    imm = '0;
    imm[IMM_W-1:0] = imm_raw_s;
    for (int i = IMM_W; i < DATA_W; i++) begin
      imm[i] = sign_ext_s & imm_raw_s[IMM_W-1];
    end
  end

endmodule

// File: rtl/inst_dec_pipe.sv
// Handshaked instruction decoder: one registered output stage backed by a
// one-entry skid register, with flush and a transfer counter.
module inst_dec_pipe
  import inst_dec_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 3,
  parameter int IMM_W    = 8,
  parameter int DATA_W   = 16,
  parameter int IMM_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_flush,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [INST_W-1:0] I_inst,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [OPC_W-1:0]  O_aluop,
  output logic [REG_AW-1:0] O_selA,
  output logic [REG_AW-1:0] O_selB,
  output logic [REG_AW-1:0] O_selD,
  output logic [DATA_W-1:0] O_imm,
  output logic              O_regwe,
  output logic [CNT_W-1:0]  O_count
);

  if (INST_W < OPC_W + 3 * REG_AW) begin : g_bad_layout
    $error("inst_dec_pipe: INST_W cannot hold opcode plus three register selects");
  end
  if (OPC_W < 4) begin : g_bad_opc
    $error("inst_dec_pipe: OPC_W must be at least 4");
  end
  if (IMM_W > DATA_W || IMM_W > INST_W) begin : g_bad_imm
    $error("inst_dec_pipe: IMM_W must fit in DATA_W and INST_W");
  end

  typedef struct packed {
    logic [OPC_W-1:0]  aluop;
    logic [REG_AW-1:0] sel_a;
    logic [REG_AW-1:0] sel_b;
    logic [REG_AW-1:0] sel_d;
    logic [DATA_W-1:0] imm;
    logic              regwe;
  } fields_t;

  logic [OPC_W-1:0]  dec_aluop_s;
  logic [REG_AW-1:0] dec_sel_a_s;
  logic [REG_AW-1:0] dec_sel_b_s;
  logic [REG_AW-1:0] dec_sel_d_s;
  logic [DATA_W-1:0] dec_imm_s;
  logic              dec_regwe_s;
  fields_t           dec_s;

  fields_t           out_r;
  fields_t           skid_r;
  logic              out_valid_r;
  logic              skid_valid_r;
  logic [CNT_W-1:0]  count_r;

  logic              ready_s;
  logic              accept_s;
  logic              xfer_s;

  inst_dec_fields #(
    .INST_W  (INST_W),
    .OPC_W   (OPC_W),
    .REG_AW  (REG_AW),
    .IMM_W   (IMM_W),
    .DATA_W  (DATA_W),
    .IMM_MODE(IMM_MODE)
  ) u_fields (
    .inst (I_inst),
    .aluop(dec_aluop_s),
    .sel_a(dec_sel_a_s),
    .sel_b(dec_sel_b_s),
    .sel_d(dec_sel_d_s),
    .imm  (dec_imm_s),
    .regwe(dec_regwe_s)
  );

  assign dec_s = {dec_aluop_s, dec_sel_a_s, dec_sel_b_s, dec_sel_d_s, dec_imm_s, dec_regwe_s};

  // Readiness depends only on held state, never on the downstream ready
  assign ready_s  = !skid_valid_r && !I_rst;
  assign accept_s = I_valid && ready_s && !I_flush;
  assign xfer_s   = out_valid_r && I_ready;

  // Output stage, skid entry and transfer counter
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_r        <= '0;
      skid_r       <= '0;
      count_r      <= '0;
    end else if (I_flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      count_r      <= '0;
    end else begin
      if (xfer_s) begin
        count_r <= count_r + CNT_W'(1);
      end
      if (!out_valid_r || I_ready) begin
        if (skid_valid_r) begin
          out_r        <= skid_r;
          out_valid_r  <= 1'b1;
          skid_valid_r <= 1'b0;
        end else if (accept_s) begin
          out_r       <= dec_s;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (accept_s) begin
        // Output is stalled: park the new beat behind it
        skid_r       <= dec_s;
        skid_valid_r <= 1'b1;
      end
    end
  end

  assign O_ready = ready_s;
  assign O_valid = out_valid_r;
  assign O_aluop = out_r.aluop;
  assign O_selA  = out_r.sel_a;
  assign O_selB  = out_r.sel_b;
  assign O_selD  = out_r.sel_d;
  assign O_imm   = out_r.imm;
  assign O_regwe = out_r.regwe;
  assign O_count = count_r;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Directed bench: four decoder variants share one stimulus stream; each
// check compares an output against a hand-computed value.
module tb_inst_dec_pipe;
  import inst_dec_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid;
  logic [15:0] inst;
  logic        ready;

  logic        z_ready, z_valid, z_regwe;
  logic [4:0]  z_aluop;
  logic [2:0]  z_sela, z_selb, z_seld;
  logic [15:0] z_imm, z_count;

  logic        s_ready, s_valid, s_regwe;
  logic [4:0]  s_aluop;
  logic [2:0]  s_sela, s_selb, s_seld;
  logic [15:0] s_imm, s_count;

  logic        p_ready, p_valid, p_regwe;
  logic [4:0]  p_aluop;
  logic [2:0]  p_sela, p_selb, p_seld;
  logic [15:0] p_imm, p_count;

  logic        c_ready, c_valid, c_regwe;
  logic [4:0]  c_aluop;
  logic [2:0]  c_sela, c_selb, c_seld;
  logic [15:0] c_imm;
  logic [3:0]  c_count;

  int n_assert = 0;
  int n_fail   = 0;

  dec_fields_t exp_f;
  logic [15:0] vec [4];
  logic        vec_we [4];

  inst_dec_pipe #(.IMM_MODE(0)) dut (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(valid), .O_ready(z_ready),
    .I_inst(inst), .O_valid(z_valid), .I_ready(ready), .O_aluop(z_aluop),
    .O_selA(z_sela), .O_selB(z_selb), .O_selD(z_seld), .O_imm(z_imm),
    .O_regwe(z_regwe), .O_count(z_count));

  inst_dec_pipe #(.IMM_MODE(1)) dut_s (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(valid), .O_ready(s_ready),
    .I_inst(inst), .O_valid(s_valid), .I_ready(ready), .O_aluop(s_aluop),
    .O_selA(s_sela), .O_selB(s_selb), .O_selD(s_seld), .O_imm(s_imm),
    .O_regwe(s_regwe), .O_count(s_count));

  inst_dec_pipe #(.IMM_MODE(2)) dut_p (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(valid), .O_ready(p_ready),
    .I_inst(inst), .O_valid(p_valid), .I_ready(ready), .O_aluop(p_aluop),
    .O_selA(p_sela), .O_selB(p_selb), .O_selD(p_seld), .O_imm(p_imm),
    .O_regwe(p_regwe), .O_count(p_count));

  inst_dec_pipe #(.CNT_W(4)) dut_c (
    .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(valid), .O_ready(c_ready),
    .I_inst(inst), .O_valid(c_valid), .I_ready(ready), .O_aluop(c_aluop),
    .O_selA(c_sela), .O_selB(c_selb), .O_selD(c_seld), .O_imm(c_imm),
    .O_regwe(c_regwe), .O_count(c_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] z_fields();
    return 64'({z_aluop, z_sela, z_selb, z_seld, z_imm, z_regwe});
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; inst = 16'h0000; ready = 1'b1;
    step();
    step();
    chk("rst_ready", 64'(z_ready), 64'd0);
    chk("rst_valid", 64'(z_valid), 64'd0);
    rst = 1'b0;
    step();
    exp_f = '0;
    chk("rst_fields", z_fields(), 64'(exp_f));
    chk("rst_count", 64'(z_count), 64'd0);
    chk("idle_ready", 64'(z_ready), 64'd1);

    // Basic decode of 16'h0A70
    valid = 1'b1; inst = 16'h0A70;
    step();
    exp_f = '{aluop: 5'h01, sel_a: 3'd2, sel_b: 3'd3, sel_d: 3'd4, imm: 16'h0070, regwe: 1'b1};
    chk("basic_valid", 64'(z_valid), 64'd1);
    chk("basic_fields", z_fields(), 64'(exp_f));
    chk("basic_count_pre", 64'(z_count), 64'd0);
    valid = 1'b0;
    step();
    chk("basic_count", 64'(z_count), 64'd1);
    chk("basic_drain", 64'(z_valid), 64'd0);

    // Back-to-back write-enable decode
    vec[0] = 16'h7000; vec_we[0] = 1'b0;
    vec[1] = 16'hC000; vec_we[1] = 1'b0;
    vec[2] = 16'hD800; vec_we[2] = 1'b0;
    vec[3] = 16'h1000; vec_we[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; inst = vec[i];
      step();
      chk($sformatf("b2b_valid%0d", i), 64'(z_valid), 64'd1);
      chk($sformatf("b2b_regwe%0d", i), 64'(z_regwe), 64'(vec_we[i]));
    end
    valid = 1'b0;
    step();
    chk("b2b_count", 64'(z_count), 64'd5);

    // Immediate extension modes
    valid = 1'b1; inst = 16'h0880;
    step();
    chk("imm_zero_op1", 64'(z_imm), 64'h0080);
    chk("imm_sign_op1", 64'(s_imm), 64'hFF80);
    chk("imm_perop_op1", 64'(p_imm), 64'hFF80);
    inst = 16'h1080;
    step();
    chk("imm_zero_op2", 64'(z_imm), 64'h0080);
    chk("imm_sign_op2", 64'(s_imm), 64'hFF80);
    chk("imm_perop_op2", 64'(p_imm), 64'h0080);
    valid = 1'b0;
    step();
    chk("imm_count", 64'(z_count), 64'd7);

    // Backpressure: A, B accepted, C held off, then drained in order
    ready = 1'b0; valid = 1'b1; inst = 16'h2001;
    step();
    chk("stall_a_out", 64'(z_aluop), 64'h04);
    chk("stall_a_ready", 64'(z_ready), 64'd1);
    inst = 16'h3002;
    step();
    chk("stall_skid_full", 64'(z_ready), 64'd0);
    chk("stall_hold1", 64'(z_aluop), 64'h04);
    inst = 16'h4003;
    step();
    chk("stall_hold2", 64'(z_aluop), 64'h04);
    chk("stall_hold2_imm", 64'(z_imm), 64'h0001);
    step();
    chk("stall_hold3_valid", 64'(z_valid), 64'd1);
    chk("stall_hold3", 64'(z_aluop), 64'h04);
    chk("stall_count", 64'(z_count), 64'd7);
    ready = 1'b1;
    step();
    chk("drain_b_valid", 64'(z_valid), 64'd1);
    chk("drain_b_op", 64'(z_aluop), 64'h06);
    chk("drain_b_imm", 64'(z_imm), 64'h0002);
    step();
    chk("drain_c_valid", 64'(z_valid), 64'd1);
    chk("drain_c_op", 64'(z_aluop), 64'h08);
    chk("drain_c_imm", 64'(z_imm), 64'h0003);
    valid = 1'b0;
    step();
    chk("drain_count", 64'(z_count), 64'd10);
    chk("drain_idle", 64'(z_valid), 64'd0);

    // Flush with skid full and a beat offered
    ready = 1'b0; valid = 1'b1; inst = 16'h2001;
    step();
    inst = 16'h3002;
    step();
    chk("fl_skid_full", 64'(z_ready), 64'd0);
    flush = 1'b1; inst = 16'h4003;
    step();
    chk("fl_valid", 64'(z_valid), 64'd0);
    chk("fl_count", 64'(z_count), 64'd0);
    chk("fl_ready", 64'(z_ready), 64'd1);
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    step();
    chk("fl_no_ghost", 64'(z_valid), 64'd0);

    // Flush drops an offered beat even while ready
    flush = 1'b1; valid = 1'b1; inst = 16'h0A70;
    step();
    chk("fl_drop_ready", 64'(z_valid), 64'd0);
    flush = 1'b0; valid = 1'b0;
    step();
    chk("fl_drop_after", 64'(z_valid), 64'd0);

    // Counter wrap on the 4-bit variant
    valid = 1'b1; inst = 16'h1000;
    for (int i = 0; i < 17; i++) begin
      step();
    end
    valid = 1'b0;
    step();
    chk("wrap_count16", 64'(z_count), 64'd17);
    chk("wrap_count4", 64'(c_count), 64'd1);

    // Reset mid-stream with skid full
    ready = 1'b0; valid = 1'b1; inst = 16'hD8FF;
    step();
    inst = 16'h3002;
    step();
    rst = 1'b1;
    step();
    exp_f = '0;
    chk("mrst_valid", 64'(z_valid), 64'd0);
    chk("mrst_fields", z_fields(), 64'(exp_f));
    chk("mrst_count", 64'(z_count), 64'd0);
    chk("mrst_ready", 64'(z_ready), 64'd0);
    rst = 1'b0; ready = 1'b1; inst = 16'h0A70;
    step();
    exp_f = '{aluop: 5'h01, sel_a: 3'd2, sel_b: 3'd3, sel_d: 3'd4, imm: 16'h0070, regwe: 1'b1};
    chk("post_rst_fields", z_fields(), 64'(exp_f));
    valid = 1'b0;
    step();
    chk("post_rst_count", 64'(z_count), 64'd1);
    chk("post_rst_count4", 64'(c_count), 64'd1);
    chk("post_rst_idle", 64'(z_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
